// File: rtl/mario_input_pkg.sv
// Shared constants and types for the Mario Bros input conditioning block:
// PS/2 scan codes, joystick bit positions and the key-latch bundle.
package mario_input_pkg;

    localparam logic [8:0] KEY_LEFT  = 9'h06B;
    localparam logic [8:0] KEY_RIGHT = 9'h074;
    localparam logic [8:0] KEY_SPACE = 9'h029;
    localparam logic [8:0] KEY_CTRL  = 9'h014;
    localparam logic [8:0] KEY_F1    = 9'h005;
    localparam logic [8:0] KEY_F2    = 9'h006;
    localparam logic [8:0] KEY_1     = 9'h016;
    localparam logic [8:0] KEY_2     = 9'h01E;
    localparam logic [8:0] KEY_5     = 9'h02E;
    localparam logic [8:0] KEY_6     = 9'h036;
    localparam logic [8:0] KEY_D     = 9'h023;
    localparam logic [8:0] KEY_G     = 9'h034;
    localparam logic [8:0] KEY_A     = 9'h01C;
    localparam logic [8:0] KEY_T     = 9'h02C;

    localparam int JOY_R      = 0;
    localparam int JOY_L      = 1;
    localparam int JOY_JUMP   = 4;
    localparam int JOY_START1 = 5;
    localparam int JOY_START2 = 6;
    localparam int JOY_COIN   = 7;
    localparam int JOY_PAUSE  = 8;

    typedef struct packed {
        logic left;
        logic right;
        logic fire;
        logic f1;
        logic f2;
        logic one;
        logic two;
        logic five;
        logic six;
        logic d;
        logic g;
        logic a;
        logic t;
    } keys_t;

    // Arrows ignore the extended bit; everything else needs an exact match.
    function automatic keys_t key_update(input keys_t k, input logic [8:0] code,
                                         input logic pressed);
        keys_t r;
        r = k;
        if (code[7:0] == KEY_LEFT[7:0]) begin
            r.left = pressed;
        end else if (code[7:0] == KEY_RIGHT[7:0]) begin
            r.right = pressed;
        end else begin
            case (code)
                KEY_SPACE, KEY_CTRL: r.fire = pressed;
                KEY_F1:              r.f1   = pressed;
                KEY_F2:              r.f2   = pressed;
                KEY_1:               r.one  = pressed;
                KEY_2:               r.two  = pressed;
                KEY_5:               r.five = pressed;
                KEY_6:               r.six  = pressed;
                KEY_D:               r.d    = pressed;
                KEY_G:               r.g    = pressed;
                KEY_A:               r.a    = pressed;
                KEY_T:               r.t    = pressed;
                default:             r      = k;
            endcase
        end
        return r;
    endfunction

endpackage

// File: rtl/mario_input_ctrl_dir_resolve.sv
// Per-player left/right conflict resolver: synchronise {L,R}, and when both
// are held report the most recently pressed direction.
module dir_resolve
    import mario_input_pkg::*;
(
    input  logic       clk_sys,
    input  logic       reset,
    input  logic [1:0] in,
    output logic [1:0] out
);

    logic [1:0] s1_q, s2_q, last_q, out_q;
    logic [1:0] s1_d, s2_d, last_d, out_d;
    logic [1:0] newly;

    always_comb begin
        s1_d  = in;
        s2_d  = s1_q;
        newly = s1_q & ~s2_q;
        last_d = last_q;
        if (newly[1]) begin
            last_d = 2'b10;
        end else if (newly[0]) begin
            last_d = 2'b01;
        end
        // Use the updated last so a fresh conflict resolves without a stale cycle.
        out_d = (s1_q == 2'b11) ? last_d : s1_q;
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            s1_q   <= 2'b00;
            s2_q   <= 2'b00;
            last_q <= 2'b00;
            out_q  <= 2'b00;
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            last_q <= last_d;
            out_q  <= out_d;
        end
    end

    assign out = out_q;

endmodule

// File: rtl/mario_input_ctrl.sv
// Player input conditioning and pause/dim control for the Mario Bros core.
// Define MARIO_KBD_EN to compile in the PS/2 keyboard decode.
module mario_input_ctrl
    import mario_input_pkg::*;
#(
    parameter logic [31:0] DIM_CYCLES   = 32'd480_000_000,
    parameter logic [23:0] COIN_STRETCH = 24'd2_400_000
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [10:0] ps2_key,
    input  logic [15:0] joy_0,
    input  logic [15:0] joy_1,
    input  logic        osd_status,
    input  logic        osd_pause_dis,
    input  logic        hs_access,
    output logic [7:0]  sw1,
    output logic [7:0]  sw2,
    output logic        pause,
    output logic        dim_video
);

    keys_t keys;

`ifdef MARIO_KBD_EN
    logic  kt_q, kt_d;
    keys_t keys_q, keys_d;

    always_comb begin
        kt_d   = kt_q;
        keys_d = keys_q;
        if (ps2_key[10] != kt_q) begin
            kt_d   = ps2_key[10];
            keys_d = key_update(keys_q, ps2_key[8:0], ps2_key[9]);
        end
    end

    // Loading kt from the live toggle keeps a level held through reset from looking like an event.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            kt_q   <= ps2_key[10];
            keys_q <= '0;
        end else begin
            kt_q   <= kt_d;
            keys_q <= keys_d;
        end
    end

    assign keys = keys_q;
`else
    logic ps2_unused;
    assign ps2_unused = ^ps2_key;
    assign keys = '0;
`endif

    logic joy_unused;
    assign joy_unused = ^{joy_0[15:9], joy_0[3:2], joy_1[15:9], joy_1[3:2]};

    logic [1:0] dir1_in, dir2_in, dir1_out, dir2_out;

    assign dir1_in = {keys.left | joy_0[JOY_L], keys.right | joy_0[JOY_R]};
    assign dir2_in = {keys.d    | joy_1[JOY_L], keys.g     | joy_1[JOY_R]};

    dir_resolve u_dir1 (
        .clk_sys (clk_sys),
        .reset   (reset),
        .in      (dir1_in),
        .out     (dir1_out)
    );

    dir_resolve u_dir2 (
        .clk_sys (clk_sys),
        .reset   (reset),
        .in      (dir2_in),
        .out     (dir2_out)
    );

    logic        raw_q, raw_d;
    logic [23:0] cnt_q, cnt_d;
    logic        ptrig_q, ptrig_d;
    logic        ptog_q, ptog_d;
    logic        pause_q, pause_d;
    logic [31:0] ptimer_q, ptimer_d;
    logic        dim_q, dim_d;
    logic [7:0]  sw1_q, sw1_d, sw2_q, sw2_d;

    logic coin, start1, start2, fire1, fire2, btn_test;

    always_comb begin
        raw_d = joy_0[JOY_COIN] | joy_1[JOY_COIN] | keys.five | keys.six;
        cnt_d = cnt_q;
        if (raw_d && !raw_q) begin
            cnt_d = COIN_STRETCH;
        end else if (cnt_q != 24'd0) begin
            cnt_d = cnt_q - 24'd1;
        end
        coin = raw_d | (cnt_q != 24'd0);

        start1   = keys.f1 | keys.one | joy_0[JOY_START1] | joy_1[JOY_START1];
        start2   = keys.f2 | keys.two | joy_0[JOY_START2] | joy_1[JOY_START2];
        fire1    = keys.fire | joy_0[JOY_JUMP];
        fire2    = keys.a    | joy_1[JOY_JUMP];
        btn_test = keys.t;

        sw1_d = ~{btn_test, start2, start1, fire1, 2'b00, dir1_out};
        sw2_d = ~{2'b00, coin, fire2, 2'b00, dir2_out};

        ptrig_d = joy_0[JOY_PAUSE] | joy_1[JOY_PAUSE];
        ptog_d  = ptog_q ^ (ptrig_d & ~ptrig_q);
        pause_d = hs_access | ptog_d | (osd_status & ~osd_pause_dis);

        // Timer clears on the edge pause drops so dim never outlives pause.
        if (!pause_d) begin
            ptimer_d = 32'd0;
        end else if (pause_q && (ptimer_q < DIM_CYCLES)) begin
            ptimer_d = ptimer_q + 32'd1;
        end else begin
            ptimer_d = ptimer_q;
        end
        dim_d = pause_d & (ptimer_d >= DIM_CYCLES);
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            raw_q    <= 1'b0;
            cnt_q    <= 24'd0;
            ptrig_q  <= 1'b0;
            ptog_q   <= 1'b0;
            pause_q  <= 1'b0;
            ptimer_q <= 32'd0;
            dim_q    <= 1'b0;
            sw1_q    <= 8'hFF;
            sw2_q    <= 8'hFF;
        end else begin
            raw_q    <= raw_d;
            cnt_q    <= cnt_d;
            ptrig_q  <= ptrig_d;
            ptog_q   <= ptog_d;
            pause_q  <= pause_d;
            ptimer_q <= ptimer_d;
            dim_q    <= dim_d;
            sw1_q    <= sw1_d;
            sw2_q    <= sw2_d;
        end
    end

    assign sw1       = sw1_q;
    assign sw2       = sw2_q;
    assign pause     = pause_q;
    assign dim_video = dim_q;

endmodule
